// File: rtl/event_trigger_mapper.sv
// Decodes EVR event codes into per-output trigger strobes via a 256-entry map and per-trigger prescalers.
// Optional per-trigger fire counters are enabled by defining EVENT_TRIGGER_MAPPER_COUNTERS_EN.
module event_trigger_mapper #(
    parameter int NUM_TRIGGERS   = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                    evrClk,
    input  logic                    evrRst_n,
    input  logic [7:0]              eventCode,
    input  logic                    eventStrobe,
    input  logic                    cfgStrobe,
    input  logic [31:0]             cfgData,
    output logic                    mapBusy,
    output logic [NUM_TRIGGERS-1:0] triggerStrobe
`ifdef EVENT_TRIGGER_MAPPER_COUNTERS_EN
    ,
    input  logic [3:0]              cntSel,
    output logic [31:0]             cntValue
`endif
);

    localparam logic [1:0] OP_MAP_WRITE    = 2'b00;
    localparam logic [1:0] OP_SET_PRESCALE = 2'b01;
    localparam logic [1:0] OP_CLEAR_MAP    = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [7:0]                clr_addr_r;
    logic [7:0]                clr_addr_next_s;
    logic                      busy_s;
    logic                      map_wr_s;
    logic                      clear_cmd_s;
    logic                      presc_wr_s;
    logic                      accept_s;
    logic                      mem_we_s;
    logic [7:0]                mem_waddr_s;
    logic [NUM_TRIGGERS-1:0]   mem_wdata_s;
    logic [NUM_TRIGGERS-1:0]   map_mem_r [256];
    logic [NUM_TRIGGERS-1:0]   rd_mask_r;
    logic                      s1_valid_r;
    logic [PRESCALE_WIDTH-1:0] presc_r      [NUM_TRIGGERS];
    logic [PRESCALE_WIDTH-1:0] presc_next_s [NUM_TRIGGERS];
    logic [PRESCALE_WIDTH-1:0] pcnt_r       [NUM_TRIGGERS];
    logic [PRESCALE_WIDTH-1:0] pcnt_next_s  [NUM_TRIGGERS];
    logic [NUM_TRIGGERS-1:0]   fire_s;
    logic [NUM_TRIGGERS-1:0]   trig_r;

    // The state register is the busy flag: busy exactly while clearing.
    assign busy_s        = (state_r == ST_CLEAR);
    assign mapBusy       = busy_s;
    assign triggerStrobe = trig_r;

    // Config command decode; map writes and events are locked out while clearing.
    always_comb begin
        map_wr_s    = 1'b0;
        clear_cmd_s = 1'b0;
        presc_wr_s  = 1'b0;
        if (cfgStrobe) begin
            case (cfgData[31:30])
                OP_MAP_WRITE:    map_wr_s    = !busy_s;
                OP_SET_PRESCALE: presc_wr_s  = 1'b1;
                OP_CLEAR_MAP:    clear_cmd_s = 1'b1;
                default:         map_wr_s    = 1'b0;
            endcase
        end else begin
            map_wr_s = 1'b0;
        end
        accept_s = eventStrobe && !busy_s && (eventCode != 8'h00);
    end

    // Clear FSM state register; reset starts a fresh clear from address 0.
    always_ff @(posedge evrClk or negedge evrRst_n) begin
        if (!evrRst_n) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= 8'd0;
        end else begin
            state_r    <= state_next_s;
            clr_addr_r <= clr_addr_next_s;
        end
    end

    // Clear FSM next state: walk addresses 0..255, restart on a new CLEAR_MAP.
    always_comb begin
        state_next_s    = state_r;
        clr_addr_next_s = clr_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_cmd_s) begin
                    state_next_s    = ST_CLEAR;
                    clr_addr_next_s = 8'd0;
                end else begin
                    clr_addr_next_s = 8'd0;
                end
            end
            ST_CLEAR: begin
                if (clear_cmd_s) begin
                    clr_addr_next_s = 8'd0;
                end else if (clr_addr_r == 8'hFF) begin
                    state_next_s    = ST_IDLE;
                    clr_addr_next_s = 8'd0;
                end else begin
                    clr_addr_next_s = clr_addr_r + 8'd1;
                end
            end
            default: begin
                state_next_s    = ST_CLEAR;
                clr_addr_next_s = 8'd0;
            end
        endcase
    end

    // Map write port mux: the clear sweep owns the port while busy.
    always_comb begin
        if (busy_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = map_wr_s;
            mem_waddr_s = cfgData[15:8];
            mem_wdata_s = cfgData[NUM_TRIGGERS-1:0];
        end
    end

    // Map RAM (no reset): the read returns the pre-write mask on a same-cycle write.
    always_ff @(posedge evrClk) begin
        if (mem_we_s) begin
            map_mem_r[mem_waddr_s] <= mem_wdata_s;
        end
        if (eventStrobe) begin
            rd_mask_r <= map_mem_r[eventCode];
        end
    end

    // Stage-1 valid flag qualifying the registered mask.
    always_ff @(posedge evrClk or negedge evrRst_n) begin
        if (!evrRst_n) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
        end
    end

    // Stage-2 prescale decision; a SET_PRESCALE to a trigger suppresses its match this cycle.
    always_comb begin
        fire_s = '0;
        for (int i = 0; i < NUM_TRIGGERS; i++) begin
            presc_next_s[i] = presc_r[i];
            pcnt_next_s[i]  = pcnt_r[i];
            if (presc_wr_s && (cfgData[27:24] == 4'(i))) begin
                presc_next_s[i] = cfgData[PRESCALE_WIDTH-1:0];
                pcnt_next_s[i]  = '0;
            end else if (s1_valid_r && rd_mask_r[i]) begin
                if (presc_r[i] <= PRESCALE_WIDTH'(1)) begin
                    fire_s[i] = 1'b1;
                end else if (pcnt_r[i] == (presc_r[i] - PRESCALE_WIDTH'(1))) begin
                    fire_s[i]      = 1'b1;
                    pcnt_next_s[i] = '0;
                end else begin
                    pcnt_next_s[i] = pcnt_r[i] + PRESCALE_WIDTH'(1);
                end
            end else begin
                pcnt_next_s[i] = pcnt_r[i];
            end
        end
    end

    // Prescale registers and registered trigger strobes.
    always_ff @(posedge evrClk or negedge evrRst_n) begin
        if (!evrRst_n) begin
            trig_r <= '0;
            for (int i = 0; i < NUM_TRIGGERS; i++) begin
                presc_r[i] <= '0;
                pcnt_r[i]  <= '0;
            end
        end else begin
            trig_r <= fire_s;
            for (int i = 0; i < NUM_TRIGGERS; i++) begin
                presc_r[i] <= presc_next_s[i];
                pcnt_r[i]  <= pcnt_next_s[i];
            end
        end
    end

`ifdef EVENT_TRIGGER_MAPPER_COUNTERS_EN
    logic [31:0] fire_cnt_r [NUM_TRIGGERS];
    logic [31:0] sel_cnt_s;
    logic [31:0] cnt_value_r;

    assign cntValue = cnt_value_r;

    // Counter readback select; unmatched selects read as zero.
    always_comb begin
        sel_cnt_s = 32'd0;
        for (int i = 0; i < NUM_TRIGGERS; i++) begin
            if (cntSel == 4'(i)) begin
                sel_cnt_s = fire_cnt_r[i];
            end else begin
                sel_cnt_s = sel_cnt_s;
            end
        end
    end

    // Fire counters (wrap at 2^32, untouched by CLEAR_MAP) and registered readback.
    always_ff @(posedge evrClk or negedge evrRst_n) begin
        if (!evrRst_n) begin
            cnt_value_r <= 32'd0;
            for (int i = 0; i < NUM_TRIGGERS; i++) begin
                fire_cnt_r[i] <= 32'd0;
            end
        end else begin
            cnt_value_r <= sel_cnt_s;
            for (int i = 0; i < NUM_TRIGGERS; i++) begin
                if (fire_s[i]) begin
                    fire_cnt_r[i] <= fire_cnt_r[i] + 32'd1;
                end else begin
                    fire_cnt_r[i] <= fire_cnt_r[i];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_event_trigger_mapper.sv
// Self-checking bench for event_trigger_mapper: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_event_trigger_mapper;

    localparam int NT = 8;

    logic          evrClk = 1'b0;
    logic          evrRst_n;
    logic [7:0]    eventCode;
    logic          eventStrobe;
    logic          cfgStrobe;
    logic [31:0]   cfgData;
    logic          mapBusy;
    logic [NT-1:0] triggerStrobe;
    logic [3:0]    cntSel;
    logic [31:0]   cntValue;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  m_map   [256];
    int unsigned m_presc [NT];
    int unsigned m_cnt   [NT];
    int unsigned m_fires [NT];
    logic [7:0]  m_pend;
    int          clr_left;
    logic [3:0]  sel_v;

    event_trigger_mapper #(.NUM_TRIGGERS(NT), .PRESCALE_WIDTH(16)) dut (
        .evrClk        (evrClk),
        .evrRst_n      (evrRst_n),
        .eventCode     (eventCode),
        .eventStrobe   (eventStrobe),
        .cfgStrobe     (cfgStrobe),
        .cfgData       (cfgData),
        .mapBusy       (mapBusy),
        .triggerStrobe (triggerStrobe)
`ifdef EVENT_TRIGGER_MAPPER_COUNTERS_EN
        ,
        .cntSel        (cntSel),
        .cntValue      (cntValue)
`endif
    );

    always #5 evrClk = ~evrClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] map_wr(input logic [7:0] c, input logic [7:0] m);
        return {2'b00, 14'h0000, c, m};
    endfunction

    function automatic logic [31:0] presc_wr(input logic [3:0] idx, input logic [15:0] v);
        return {2'b01, 2'b00, idx, 8'h00, v};
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 256; a++) m_map[a] = 8'h00;
        for (int i = 0; i < NT; i++) begin
            m_presc[i] = 0;
            m_cnt[i]   = 0;
            m_fires[i] = 0;
        end
        m_pend   = 8'h00;
        clr_left = 256;
    endtask

    // One clock cycle: drive inputs, advance the model, check outputs 1ns after the edge.
    task automatic cyc(input logic es, input logic [7:0] code, input logic cs, input logic [31:0] cd);
        logic [7:0]  fire;
        logic [1:0]  op;
        logic        busy_now;
        logic [31:0] exp_cnt;
        eventStrobe = es;
        eventCode   = code;
        cfgStrobe   = cs;
        cfgData     = cd;
        cntSel      = sel_v;
        busy_now    = (clr_left > 0);
        op          = cs ? cd[31:30] : 2'b11;
        fire        = 8'h00;
        for (int i = 0; i < NT; i++) begin
            if (op == 2'b01 && int'(cd[27:24]) == i) begin
                m_presc[i] = int'(cd[15:0]);
                m_cnt[i]   = 0;
            end else if (m_pend[i]) begin
                if (m_presc[i] <= 1) begin
                    fire[i] = 1'b1;
                end else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == m_presc[i]) begin
                        fire[i]  = 1'b1;
                        m_cnt[i] = 0;
                    end
                end
            end
        end
        exp_cnt = (int'(sel_v) < NT) ? m_fires[sel_v] : 32'd0;
        for (int i = 0; i < NT; i++) m_fires[i] += int'(fire[i]);
        m_pend = (es && !busy_now && code != 8'h00) ? m_map[code] : 8'h00;
        if (op == 2'b00 && !busy_now) m_map[cd[15:8]] = cd[7:0];
        if (op == 2'b10) begin
            clr_left = 256;
            for (int a = 0; a < 256; a++) m_map[a] = 8'h00;
        end else if (clr_left > 0) begin
            clr_left--;
        end
        @(posedge evrClk);
        #1;
        chk("trigger_model", 32'(triggerStrobe), 32'(fire));
        chk("busy_model", 32'(mapBusy), 32'(clr_left > 0));
`ifdef EVENT_TRIGGER_MAPPER_COUNTERS_EN
        chk("cnt_model", cntValue, exp_cnt);
`endif
    endtask

    initial begin
        int n;
        int r;
        logic [7:0] c;
        evrRst_n    = 1'b0;
        eventStrobe = 1'b1;
        eventCode   = 8'h21;
        cfgStrobe   = 1'b0;
        cfgData     = 32'h0;
        sel_v       = 4'd0;
        cntSel      = 4'd0;
        model_reset();
        repeat (3) @(posedge evrClk);
        #1;
        chk("reset_trig", 32'(triggerStrobe), 32'h0);
        chk("reset_busy", 32'(mapBusy), 32'h1);
        @(negedge evrClk);
        evrRst_n = 1'b1;

        // startup clear with a continuous 0x21 stream
        n = 0;
        while (mapBusy && n < 300) begin
            cyc(1'b1, 8'h21, 1'b0, 32'h0);
            n++;
        end
        chk("startup_busy_len", 32'(n), 32'd256);

        // basic mapping and null code
        cyc(1'b0, 8'h00, 1'b1, map_wr(8'h21, 8'h05));
        cyc(1'b0, 8'h00, 1'b1, map_wr(8'h00, 8'hFF));
        cyc(1'b1, 8'h21, 1'b0, 32'h0);
        chk("latency_n1", 32'(triggerStrobe), 32'h0);
        cyc(1'b1, 8'h22, 1'b0, 32'h0);
        chk("map_0x21", 32'(triggerStrobe), 32'h05);
        cyc(1'b1, 8'h00, 1'b0, 32'h0);
        chk("unmapped_0x22", 32'(triggerStrobe), 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 32'h0);
        chk("null_code", 32'(triggerStrobe), 32'h0);

        // prescale 3 on trigger 0
        cyc(1'b0, 8'h00, 1'b1, presc_wr(4'd0, 16'd3));
        for (int j = 1; j <= 12; j++) begin
            cyc((j <= 10), 8'h21, 1'b0, 32'h0);
            if (j >= 2 && j <= 11) begin
                chk("prescale3", 32'(triggerStrobe), ((j - 1) % 3 == 0) ? 32'h05 : 32'h04);
            end
        end

        // same-cycle map write and event: old mask, then new
        cyc(1'b0, 8'h00, 1'b1, presc_wr(4'd0, 16'd0));
        cyc(1'b1, 8'h21, 1'b1, map_wr(8'h21, 8'h02));
        cyc(1'b1, 8'h21, 1'b0, 32'h0);
        chk("rbw_old", 32'(triggerStrobe), 32'h05);
        cyc(1'b0, 8'h00, 1'b0, 32'h0);
        chk("rbw_new", 32'(triggerStrobe), 32'h02);

        // clear mid-stream
        cyc(1'b1, 8'h21, 1'b1, 32'h8000_0000);
        n = 0;
        while (mapBusy && n < 300) begin
            cyc(1'b1, 8'h21, 1'b1, map_wr(8'h21, 8'hFF));
            n++;
        end
        chk("clear_busy_len", 32'(n), 32'd256);
        cyc(1'b1, 8'h21, 1'b0, 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 32'h0);
        chk("after_clear", 32'(triggerStrobe), 32'h0);

        // reset mid-pipeline
        cyc(1'b0, 8'h00, 1'b1, map_wr(8'h21, 8'h05));
        cyc(1'b1, 8'h21, 1'b0, 32'h0);
        cyc(1'b1, 8'h21, 1'b0, 32'h0);
        chk("pre_reset_trig", 32'(triggerStrobe), 32'h05);
        #1;
        evrRst_n = 1'b0;
        #1;
        chk("async_reset_trig", 32'(triggerStrobe), 32'h0);
        chk("async_reset_busy", 32'(mapBusy), 32'h1);
        model_reset();
        @(posedge evrClk);
        @(negedge evrClk);
        evrRst_n = 1'b1;
        n = 0;
        while (mapBusy && n < 300) begin
            cyc(1'b1, 8'h21, 1'b0, 32'h0);
            n++;
        end
        chk("reset_clear_len", 32'(n), 32'd256);

`ifdef EVENT_TRIGGER_MAPPER_COUNTERS_EN
        cyc(1'b0, 8'h00, 1'b1, map_wr(8'h21, 8'h04));
        repeat (7) cyc(1'b1, 8'h21, 1'b0, 32'h0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0, 32'h0);
        sel_v = 4'd2;
        cyc(1'b0, 8'h00, 1'b0, 32'h0);
        chk("cnt_sel2", cntValue, 32'd7);
        sel_v = 4'd9;
        cyc(1'b0, 8'h00, 1'b0, 32'h0);
        chk("cnt_sel9", cntValue, 32'd0);
`endif

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 3));
            c = (r == 0) ? 8'h00 : (r == 1) ? 8'h21 : (r == 2) ? 8'h22 : 8'($urandom_range(0, 255));
            sel_v = 4'($urandom_range(0, 15));
            r = int'($urandom_range(0, 19));
            if (r < 6) begin
                cyc(1'($urandom_range(0, 1)), c, 1'b1,
                    map_wr(($urandom_range(0, 1) == 1) ? 8'h21 : c, 8'($urandom)));
            end else if (r < 9) begin
                cyc(1'($urandom_range(0, 1)), c, 1'b1,
                    presc_wr(4'($urandom_range(0, 11)), 16'($urandom_range(0, 4))));
            end else if (r == 9) begin
                cyc(1'($urandom_range(0, 1)), c, 1'b1, {2'b11, 30'($urandom)});
            end else if (r == 10 && $urandom_range(0, 7) == 0) begin
                cyc(1'b1, c, 1'b1, 32'h8000_0000);
            end else begin
                cyc(($urandom_range(0, 3) != 0), c, 1'b0, 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
